// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write path.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer holding long-latency unit results until they win the write port.
module rf_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    // Push is judged on the registered full flag, so a same-cycle pop never frees a slot early.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: ALU results take priority over buffered LU results.
module rf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int LU_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wr,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic              q1_fwd,
    output logic              q2_fwd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              RegWrite
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t            lu_in;
    req_t            head;
    req_t            win;
    logic            full;
    logic            empty;
    logic            win_vld;
    logic            win_lu;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_nxt;

    assign lu_in    = '{addr: lu_addr, data: lu_data};
    assign lu_ready = !full;

    rf_wb_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (LU_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lu_valid),
        .pop   (win_lu),
        .din   (lu_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        win_lu  = !alu_wr && !empty;
        win_vld = alu_wr || !empty;
        win     = alu_wr ? '{addr: alu_addr, data: alu_data} : head;
    end

    // Writes to r0 still consume the winner and move w_addr/w_data, only the enable is held low.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            RegWrite <= win_vld && (win.addr != ZERO);
            if (win_vld) begin
                w_addr <= win.addr;
                w_data <= win.data;
            end
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the register pending.
    always_comb begin
        sb_nxt = sb;
        if (win_lu) sb_nxt[head.addr] = 1'b0;
        if (sb_set) sb_nxt[sb_addr]   = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) sb <= '0;
        else     sb <= sb_nxt;
    end

    assign q1_busy  = sb[q1_addr];
    assign q2_busy  = sb[q2_addr];
    assign q1_fwd   = RegWrite && (w_addr == q1_addr) && (q1_addr != ZERO);
    assign q2_fwd   = RegWrite && (w_addr == q2_addr) && (q2_addr != ZERO);
    assign fwd_data = w_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a reference model predicts writes, busy bits and forwarding.
module tb_rf_wb_arbiter;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_wr;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [ADDR_W-1:0] q1_addr;
    logic [ADDR_W-1:0] q2_addr;
    logic              q1_busy;
    logic              q2_busy;
    logic              q1_fwd;
    logic              q2_fwd;
    logic [DATA_W-1:0] fwd_data;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              RegWrite;

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LU_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_wr(alu_wr), .alu_addr(alu_addr), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .q1_addr(q1_addr), .q2_addr(q2_addr),
        .q1_busy(q1_busy), .q2_busy(q2_busy), .q1_fwd(q1_fwd), .q2_fwd(q2_fwd),
        .fwd_data(fwd_data), .w_addr(w_addr), .w_data(w_data), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, advanced on every posedge from the inputs it samples.
    wr_req_t        mq[$];
    wr_req_t        eq[$];
    logic [31:0]    msb;
    logic           mrw;
    logic [4:0]     mwa;
    logic [31:0]    mwd;
    wr_req_t        mw;
    logic           m_vld, m_lu, m_acc;
    logic           chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            eq.delete();
            msb = '0; mrw = 1'b0; mwa = '0; mwd = '0;
        end else begin
            m_acc = lu_valid && (mq.size() < DEPTH);
            m_vld = 1'b0; m_lu = 1'b0;
            if (alu_wr) begin
                mw = '{addr: alu_addr, data: alu_data};
                m_vld = 1'b1;
            end else if (mq.size() > 0) begin
                mw = mq.pop_front();
                m_vld = 1'b1; m_lu = 1'b1;
            end
            if (m_acc) mq.push_back('{addr: lu_addr, data: lu_data});
            if (m_lu) msb[mw.addr] = 1'b0;
            if (sb_set) msb[sb_addr] = 1'b1;
            msb[0] = 1'b0;
            mrw = m_vld && (mw.addr != 0);
            if (m_vld) begin mwa = mw.addr; mwd = mw.data; end
            if (mrw) eq.push_back(mw);
        end
    end

    wr_req_t e;
    always @(negedge clk) begin
        if (chk_en) begin
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("sb_rw", 32'(RegWrite), 32'd1);
                chk("sb_waddr", 32'(w_addr), 32'(e.addr));
                chk("sb_wdata", w_data, e.data);
            end else begin
                chk("sb_rw_idle", 32'(RegWrite), 32'd0);
                chk("sb_waddr_hold", 32'(w_addr), 32'(mwa));
            end
            chk("m_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
            chk("m_busy1", 32'(q1_busy), 32'(msb[q1_addr]));
            chk("m_busy2", 32'(q2_busy), 32'(msb[q2_addr]));
            chk("m_fwd1", 32'(q1_fwd), 32'(mrw && mwa == q1_addr && q1_addr != 0));
            chk("m_fwd2", 32'(q2_fwd), 32'(mrw && mwa == q2_addr && q2_addr != 0));
            chk("m_fwdd", fwd_data, mwd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; alu_wr = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
        sb_set = 1'b0; sb_addr = '0; q1_addr = 5'd3; q2_addr = 5'd8;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_rw", 32'(RegWrite), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd1);
        chk("rst_busy", 32'({q1_busy, q2_busy}), 32'd0);
        chk("rst_wdata", w_data, 32'd0);

        rst = 1'b0;
        step();
        chk("alu_rw", 32'(RegWrite), 32'd1);
        chk("alu_waddr", 32'(w_addr), 32'd3);
        chk("alu_wdata", w_data, 32'h11);
        alu_wr = 1'b0;

        // LU path through the buffer
        sb_set = 1'b1; sb_addr = 5'd8; q1_addr = 5'd8;
        step();
        sb_set = 1'b0;
        chk("lu_busy_set", 32'(q1_busy), 32'd1);
        lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'hCAFE;
        step();
        lu_valid = 1'b0;
        chk("lu_busy_buf", 32'(q1_busy), 32'd1);
        chk("lu_rw_wait", 32'(RegWrite), 32'd0);
        step();
        chk("lu_rw", 32'(RegWrite), 32'd1);
        chk("lu_waddr", 32'(w_addr), 32'd8);
        chk("lu_wdata", w_data, 32'hCAFE);
        chk("lu_busy_clr", 32'(q1_busy), 32'd0);

        // Back-pressure while the ALU holds the port
        sb_set = 1'b1; sb_addr = 5'd5; step();
        sb_addr = 5'd6; step();
        sb_set = 1'b0;
        alu_wr = 1'b1; alu_addr = 5'd1; alu_data = 32'hA1;
        lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h55;
        step();
        lu_addr = 5'd6; lu_data = 32'h66; alu_data = 32'hA2;
        step();
        chk("bp_full", 32'(lu_ready), 32'd0);
        lu_addr = 5'd7; lu_data = 32'h77; alu_data = 32'hA3;
        step();
        chk("bp_still_full", 32'(lu_ready), 32'd0);
        alu_wr = 1'b0;
        step();
        chk("bp_first", 32'(w_addr), 32'd5);
        chk("bp_ready_back", 32'(lu_ready), 32'd1);
        step();
        lu_valid = 1'b0;
        chk("bp_second", 32'(w_addr), 32'd6);
        step();
        chk("bp_third", 32'(w_addr), 32'd7);
        chk("bp_third_d", w_data, 32'h77);

        // Register 0
        alu_wr = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF; q1_addr = 5'd0;
        step();
        alu_wr = 1'b0;
        chk("r0_rw", 32'(RegWrite), 32'd0);
        chk("r0_fwd", 32'(q1_fwd), 32'd0);
        chk("r0_wdata", w_data, 32'hFF);
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hAB;
        step();
        lu_valid = 1'b0;
        step();
        chk("r0_lu_rw", 32'(RegWrite), 32'd0);
        chk("r0_lu_wdata", w_data, 32'hAB);
        chk("r0_lu_ready", 32'(lu_ready), 32'd1);

        // Clear and re-set of the same register in one cycle
        sb_set = 1'b1; sb_addr = 5'd9; q1_addr = 5'd9;
        step();
        sb_set = 1'b0;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
        step();
        lu_valid = 1'b0; sb_set = 1'b1;
        step();
        sb_set = 1'b0;
        chk("sc_waddr", 32'(w_addr), 32'd9);
        chk("sc_busy", 32'(q1_busy), 32'd1);

        // Forwarding window
        alu_wr = 1'b1; alu_addr = 5'd4; alu_data = 32'h1234; q1_addr = 5'd4;
        step();
        alu_wr = 1'b0;
        chk("fw_fwd", 32'(q1_fwd), 32'd1);
        chk("fw_data", fwd_data, 32'h1234);
        step();
        chk("fw_gone", 32'(q1_fwd), 32'd0);

        // Random traffic with a mid-run reset, checked against the model
        for (int i = 0; i < 300; i++) begin
            rst      = (i == 150);
            alu_wr   = ($urandom_range(0, 2) == 0);
            alu_addr = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            lu_valid = ($urandom_range(0, 1) == 0);
            lu_addr  = 5'($urandom_range(0, 31));
            lu_data  = $urandom;
            sb_set   = ($urandom_range(0, 3) == 0);
            sb_addr  = 5'($urandom_range(0, 31));
            q1_addr  = 5'($urandom_range(0, 31));
            q2_addr  = (i % 2 == 0) ? alu_addr : lu_addr;
            step();
        end
        rst = 1'b0; alu_wr = 1'b0; lu_valid = 1'b0; sb_set = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
